// File: rtl/rxiod_link_bringup_seq.sv
// RX IOD link bring-up sequencer: PLL lock -> clock training -> bit alignment ->
// PRBS qualification, with bounded retries and a sticky FAIL until LINK_EN drops.
module rxiod_link_bringup_seq #(
  parameter int TMR_W         = 16,
  parameter int TRAIN_TIMEOUT = 50000,
  parameter int ALGN_TIMEOUT  = 50000,
  parameter int SETTLE_CYCLES = 256,
  parameter int PRBS_WINDOW   = 4096,
  parameter int ERR_THRESH    = 0,
  parameter int MAX_RETRIES   = 3
) (
  input  logic        SCLK,
  input  logic        RESET,
  input  logic        LINK_EN,
  input  logic        PLL_LOCK,
  input  logic        CLK_TRAIN_DONE,
  input  logic        CLK_TRAIN_ERROR,
  input  logic        BIT_ALGN_DONE,
  input  logic        BIT_ALGN_ERR,
  input  logic        BIT_ALGN_OOR,
  input  logic        PRBS_ERR,
  output logic        RX_CLK_TRAIN_RESTART,
  output logic        BIT_ALGN_RSTRT,
  output logic        BIT_ALGN_HOLD,
  output logic        PRBS_CHK_EN,
  output logic        LINK_UP,
  output logic        LINK_FAIL,
  output logic [1:0]  RETRY_CNT,
  output logic [2:0]  STATE,
  output logic [15:0] PRBS_ERR_CNT
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] S_CLK_TRAIN  = 3'd2;
  localparam logic [2:0] S_BIT_ALGN   = 3'd3;
  localparam logic [2:0] S_SETTLE     = 3'd4;
  localparam logic [2:0] S_PRBS_CHECK = 3'd5;
  localparam logic [2:0] S_LINK_UP    = 3'd6;
  localparam logic [2:0] S_FAIL       = 3'd7;

  localparam logic [TMR_W-1:0] TRAIN_LAST  = TMR_W'(TRAIN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] ALGN_LAST   = TMR_W'(ALGN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(PRBS_WINDOW - 1);
  localparam logic [TMR_W-1:0] TMR_MAX     = {TMR_W{1'b1}};
  localparam logic [15:0]      ERR_LIM     = 16'(ERR_THRESH);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

  // Synchronizer bit order: {PLL_LOCK, CLK_TRAIN_DONE, CLK_TRAIN_ERROR}
  logic [2:0]       sync_meta_q, sync_meta_d;
  logic [2:0]       sync_q, sync_d;
  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [1:0]       retry_cnt_q, retry_cnt_d;
  logic [15:0]      prbs_cnt_q, prbs_cnt_d;
  logic             restart_q, restart_d;
  logic             rstrt_q, rstrt_d;
  logic             hold_q, hold_d;
  logic             chk_en_q, chk_en_d;
  logic             link_up_q, link_up_d;
  logic             link_fail_q, link_fail_d;

  logic        lock_s, train_done_s, train_err_s;
  logic        retry_req;
  logic [15:0] prbs_cnt_inc;

  assign lock_s       = sync_q[2];
  assign train_done_s = sync_q[1];
  assign train_err_s  = sync_q[0];

  // The window verdict must include the error of its own last cycle.
  assign prbs_cnt_inc = (PRBS_ERR && (prbs_cnt_q != 16'hFFFF)) ? prbs_cnt_q + 16'd1 : prbs_cnt_q;

  always_comb begin
    sync_meta_d = {PLL_LOCK, CLK_TRAIN_DONE, CLK_TRAIN_ERROR};
    sync_d      = sync_meta_q;
    state_d     = state_q;
    retry_req   = 1'b0;

    // Error and timeout win over done, except done on the timeout cycle succeeds.
    case (state_q)
      S_IDLE:      if (LINK_EN) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: if (lock_s) state_d = S_CLK_TRAIN;
      S_CLK_TRAIN: begin
        if (train_err_s)              retry_req = 1'b1;
        else if (train_done_s)        state_d   = S_BIT_ALGN;
        else if (timer_q == TRAIN_LAST) retry_req = 1'b1;
      end
      S_BIT_ALGN: begin
        if (BIT_ALGN_ERR || BIT_ALGN_OOR) retry_req = 1'b1;
        else if (BIT_ALGN_DONE)           state_d   = S_SETTLE;
        else if (timer_q == ALGN_LAST)    retry_req = 1'b1;
      end
      S_SETTLE:    if (timer_q == SETTLE_LAST) state_d = S_PRBS_CHECK;
      S_PRBS_CHECK: begin
        if (timer_q == WINDOW_LAST) begin
          if (prbs_cnt_inc <= ERR_LIM) state_d   = S_LINK_UP;
          else                         retry_req = 1'b1;
        end
      end
      S_LINK_UP:   if (!lock_s || !train_done_s) retry_req = 1'b1;
      default:     state_d = S_FAIL;
    endcase

    retry_cnt_d = (state_q == S_IDLE) ? 2'd0 : retry_cnt_q;
    if (retry_req) begin
      if (retry_cnt_q < RETRY_MAX) begin
        retry_cnt_d = retry_cnt_q + 2'd1;
        state_d     = S_WAIT_LOCK;
      end else begin
        state_d     = S_FAIL;
      end
    end

    if (!LINK_EN) begin
      state_d     = S_IDLE;
      retry_cnt_d = 2'd0;
    end

    if (!LINK_EN)
      prbs_cnt_d = 16'd0;
    else if ((state_d == S_PRBS_CHECK) && (state_q != S_PRBS_CHECK))
      prbs_cnt_d = 16'd0;
    else if ((state_q == S_PRBS_CHECK) || (state_q == S_LINK_UP))
      prbs_cnt_d = prbs_cnt_inc;
    else
      prbs_cnt_d = prbs_cnt_q;

    if (state_d != state_q)
      timer_d = '0;
    else if (timer_q == TMR_MAX)
      timer_d = timer_q;
    else
      timer_d = timer_q + 1'b1;

    restart_d   = (state_d == S_CLK_TRAIN) && (state_q != S_CLK_TRAIN);
    rstrt_d     = (state_d == S_BIT_ALGN) && (state_q != S_BIT_ALGN);
    hold_d      = (state_d == S_LINK_UP);
    chk_en_d    = (state_d == S_PRBS_CHECK) || (state_d == S_LINK_UP);
    link_up_d   = (state_d == S_LINK_UP);
    link_fail_d = (state_d == S_FAIL);
  end

  always_ff @(posedge SCLK) begin
    if (RESET) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
      state_q     <= S_IDLE;
      timer_q     <= '0;
      retry_cnt_q <= '0;
      prbs_cnt_q  <= '0;
      restart_q   <= 1'b0;
      rstrt_q     <= 1'b0;
      hold_q      <= 1'b0;
      chk_en_q    <= 1'b0;
      link_up_q   <= 1'b0;
      link_fail_q <= 1'b0;
    end else begin
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_cnt_q <= retry_cnt_d;
      prbs_cnt_q  <= prbs_cnt_d;
      restart_q   <= restart_d;
      rstrt_q     <= rstrt_d;
      hold_q      <= hold_d;
      chk_en_q    <= chk_en_d;
      link_up_q   <= link_up_d;
      link_fail_q <= link_fail_d;
    end
  end

  assign RX_CLK_TRAIN_RESTART = restart_q;
  assign BIT_ALGN_RSTRT       = rstrt_q;
  assign BIT_ALGN_HOLD        = hold_q;
  assign PRBS_CHK_EN          = chk_en_q;
  assign LINK_UP              = link_up_q;
  assign LINK_FAIL            = link_fail_q;
  assign RETRY_CNT            = retry_cnt_q;
  assign STATE                = state_q;
  assign PRBS_ERR_CNT         = prbs_cnt_q;

endmodule

// File: tb/tb_rxiod_link_bringup_seq.sv
// Directed bench for the link bring-up sequencer, run with short timeouts and windows
// so every path, including retries and FAIL, completes in a few hundred cycles.
module tb_rxiod_link_bringup_seq;

  logic        SCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        LINK_EN, PLL_LOCK, CLK_TRAIN_DONE, CLK_TRAIN_ERROR;
  logic        BIT_ALGN_DONE, BIT_ALGN_ERR, BIT_ALGN_OOR, PRBS_ERR;
  logic        RX_CLK_TRAIN_RESTART, BIT_ALGN_RSTRT, BIT_ALGN_HOLD, PRBS_CHK_EN;
  logic        LINK_UP, LINK_FAIL;
  logic [1:0]  RETRY_CNT;
  logic [2:0]  STATE;
  logic [15:0] PRBS_ERR_CNT;

  int tests_run = 0;
  int tests_failed = 0;

  rxiod_link_bringup_seq #(
    .TMR_W(16), .TRAIN_TIMEOUT(100), .ALGN_TIMEOUT(100), .SETTLE_CYCLES(8),
    .PRBS_WINDOW(64), .ERR_THRESH(0), .MAX_RETRIES(2)
  ) dut (
    .SCLK(SCLK), .RESET(RESET), .LINK_EN(LINK_EN), .PLL_LOCK(PLL_LOCK),
    .CLK_TRAIN_DONE(CLK_TRAIN_DONE), .CLK_TRAIN_ERROR(CLK_TRAIN_ERROR),
    .BIT_ALGN_DONE(BIT_ALGN_DONE), .BIT_ALGN_ERR(BIT_ALGN_ERR), .BIT_ALGN_OOR(BIT_ALGN_OOR),
    .PRBS_ERR(PRBS_ERR), .RX_CLK_TRAIN_RESTART(RX_CLK_TRAIN_RESTART),
    .BIT_ALGN_RSTRT(BIT_ALGN_RSTRT), .BIT_ALGN_HOLD(BIT_ALGN_HOLD),
    .PRBS_CHK_EN(PRBS_CHK_EN), .LINK_UP(LINK_UP), .LINK_FAIL(LINK_FAIL),
    .RETRY_CNT(RETRY_CNT), .STATE(STATE), .PRBS_ERR_CNT(PRBS_ERR_CNT)
  );

  always #5 SCLK = ~SCLK;

  // Passive log sampled 2 time units after each rising edge; the main flow only reads it.
  int         cycle_num = 0;
  int         restart_times[$];
  int         rstrt_times[$];
  logic [2:0] state_log[$];
  logic [2:0] mon_last_state = 3'd0;

  always begin
    @(posedge SCLK);
    #2;
    cycle_num++;
    if (RX_CLK_TRAIN_RESTART === 1'b1) restart_times.push_back(cycle_num);
    if (BIT_ALGN_RSTRT === 1'b1) rstrt_times.push_back(cycle_num);
    if (STATE !== mon_last_state) begin
      state_log.push_back(STATE);
      mon_last_state = STATE;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic lock, input logic tdone, input logic terr,
                               input logic adone, input logic aerr, input logic aoor, input logic perr);
    LINK_EN = en; PLL_LOCK = lock; CLK_TRAIN_DONE = tdone; CLK_TRAIN_ERROR = terr;
    BIT_ALGN_DONE = adone; BIT_ALGN_ERR = aerr; BIT_ALGN_OOR = aoor; PRBS_ERR = perr;
  endtask

  task automatic step_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge SCLK);
  endtask

  task automatic reset_dut();
    RESET = 1'b1;
    step_cycles(3);
    RESET = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    int n = 0;
    while (STATE !== target && n < budget) begin
      @(negedge SCLK);
      n++;
    end
    checkOutput(tag, 32'(STATE), 32'(target));
  endtask

  function automatic logic [31:0] out_vec();
    return {5'd0, RX_CLK_TRAIN_RESTART, BIT_ALGN_RSTRT, BIT_ALGN_HOLD, PRBS_CHK_EN,
            LINK_UP, LINK_FAIL, RETRY_CNT, STATE, PRBS_ERR_CNT};
  endfunction

  initial begin
    int base_log, base_rs, base_ra, fail_cycle;
    int t0, t1, t2;
    logic [31:0] seq;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step_cycles(1);
    reset_dut();
    checkOutput("reset_outputs", out_vec(), 32'h0);

    // Nominal bring-up.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    step_cycles(3);
    checkOutput("idle_without_en", 32'(STATE), 32'd0);
    base_log = state_log.size(); base_rs = restart_times.size(); base_ra = rstrt_times.size();
    LINK_EN = 1'b1;
    wait_state(3'd2, 10, "nom_reach_train");
    checkOutput("nom_restart_pulse", 32'(RX_CLK_TRAIN_RESTART), 32'd1);
    step_cycles(1);
    checkOutput("nom_restart_one_cycle", 32'(RX_CLK_TRAIN_RESTART), 32'd0);
    step_cycles(9);
    CLK_TRAIN_DONE = 1'b1;
    step_cycles(2);
    checkOutput("nom_done_sync_latency", 32'(STATE), 32'd2);
    step_cycles(1);
    checkOutput("nom_in_bit_algn", 32'(STATE), 32'd3);
    checkOutput("nom_rstrt_pulse", 32'(BIT_ALGN_RSTRT), 32'd1);
    step_cycles(20);
    BIT_ALGN_DONE = 1'b1;
    step_cycles(1);
    BIT_ALGN_DONE = 1'b0;
    checkOutput("nom_in_settle", 32'(STATE), 32'd4);
    step_cycles(8);
    checkOutput("nom_in_prbs", 32'(STATE), 32'd5);
    checkOutput("nom_prbs_chk_en", 32'(PRBS_CHK_EN), 32'd1);
    step_cycles(63);
    checkOutput("nom_window_last", 32'(STATE), 32'd5);
    step_cycles(1);
    checkOutput("nom_link_up_state", 32'(STATE), 32'd6);
    checkOutput("nom_link_flags", {29'd0, LINK_UP, BIT_ALGN_HOLD, LINK_FAIL}, 32'b110);
    checkOutput("nom_retry_cnt", 32'(RETRY_CNT), 32'd0);
    step_cycles(2);
    checkOutput("nom_restart_count", 32'(restart_times.size() - base_rs), 32'd1);
    checkOutput("nom_rstrt_count", 32'(rstrt_times.size() - base_ra), 32'd1);
    checkOutput("nom_state_changes", 32'(state_log.size() - base_log), 32'd6);
    seq = 32'h0;
    for (int i = base_log; i < state_log.size(); i++) seq = (seq << 4) | 32'(state_log[i]);
    checkOutput("nom_state_sequence", seq, 32'h123456);

    // Training timeout until retries run out.
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    reset_dut();
    base_rs = restart_times.size();
    wait_state(3'd7, 400, "to_reach_fail");
    fail_cycle = cycle_num;
    checkOutput("to_restart_count", 32'(restart_times.size() - base_rs), 32'd3);
    t0 = -1000; t1 = -2000; t2 = -3000;
    if (restart_times.size() >= base_rs + 3) begin
      t0 = restart_times[base_rs]; t1 = restart_times[base_rs + 1]; t2 = restart_times[base_rs + 2];
    end
    checkOutput("to_gap_1", 32'(t1 - t0), 32'd101);
    checkOutput("to_gap_2", 32'(t2 - t1), 32'd101);
    checkOutput("to_fail_time", 32'(fail_cycle - t0), 32'd302);
    checkOutput("to_fail_flags", {30'd0, LINK_FAIL, LINK_UP}, 32'b10);
    checkOutput("to_retry_cnt", 32'(RETRY_CNT), 32'd2);
    step_cycles(5);
    checkOutput("to_fail_held", 32'(STATE), 32'd7);
    LINK_EN = 1'b0;
    step_cycles(1);
    checkOutput("to_release_state_retry", {27'd0, STATE, RETRY_CNT}, 32'h0);

    // PRBS failure on the last window cycle, then a clean pass.
    applyStimulus(1, 1, 1, 0, 1, 0, 0, 0);
    reset_dut();
    wait_state(3'd5, 40, "prbs_first_window");
    step_cycles(63);
    checkOutput("prbs_window_last", 32'(STATE), 32'd5);
    PRBS_ERR = 1'b1;
    step_cycles(1);
    PRBS_ERR = 1'b0;
    checkOutput("prbs_err_cnt_1", 32'(PRBS_ERR_CNT), 32'd1);
    checkOutput("prbs_retry_cnt_1", 32'(RETRY_CNT), 32'd1);
    checkOutput("prbs_retry_state", 32'(STATE), 32'd1);
    step_cycles(2);
    checkOutput("prbs_cnt_held", 32'(PRBS_ERR_CNT), 32'd1);
    wait_state(3'd5, 40, "prbs_second_window");
    checkOutput("prbs_cnt_cleared", 32'(PRBS_ERR_CNT), 32'd0);
    wait_state(3'd6, 100, "prbs_second_link_up");
    checkOutput("prbs_second_flags", {29'd0, LINK_UP, RETRY_CNT}, 32'b101);
    PRBS_ERR = 1'b1;
    step_cycles(2);
    PRBS_ERR = 1'b0;
    step_cycles(1);
    checkOutput("prbs_cnt_in_link_up", 32'(PRBS_ERR_CNT), 32'd2);
    checkOutput("prbs_link_kept", 32'(STATE), 32'd6);

    // Simultaneous DONE+OOR, then DONE on the timeout cycle.
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    reset_dut();
    wait_state(3'd3, 20, "sim_reach_algn");
    BIT_ALGN_DONE = 1'b1; BIT_ALGN_OOR = 1'b1;
    step_cycles(1);
    BIT_ALGN_DONE = 1'b0; BIT_ALGN_OOR = 1'b0;
    checkOutput("sim_done_oor_retry", {27'd0, STATE, RETRY_CNT}, {27'd0, 3'd1, 2'd1});
    step_cycles(1);
    checkOutput("sim_retrain_pulse", {28'd0, STATE, RX_CLK_TRAIN_RESTART}, {28'd0, 3'd2, 1'b1});
    step_cycles(1);
    checkOutput("sim_realign_pulse", {28'd0, STATE, BIT_ALGN_RSTRT}, {28'd0, 3'd3, 1'b1});
    step_cycles(99);
    checkOutput("sim_timer_99", 32'(STATE), 32'd3);
    BIT_ALGN_DONE = 1'b1;
    step_cycles(1);
    BIT_ALGN_DONE = 1'b0;
    checkOutput("sim_done_at_timeout", 32'(STATE), 32'd4);

    // Alignment timeout alone.
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    reset_dut();
    wait_state(3'd3, 20, "algn_to_reach");
    step_cycles(99);
    checkOutput("algn_to_before", 32'(STATE), 32'd3);
    step_cycles(1);
    checkOutput("algn_to_retry", {27'd0, STATE, RETRY_CNT}, {27'd0, 3'd1, 2'd1});

    // Loss of lock while up.
    applyStimulus(1, 1, 1, 0, 1, 0, 0, 0);
    reset_dut();
    wait_state(3'd6, 200, "lol_reach_up");
    PLL_LOCK = 1'b0;
    step_cycles(2);
    checkOutput("lol_still_up", 32'(STATE), 32'd6);
    step_cycles(1);
    checkOutput("lol_left_up", {27'd0, STATE, RETRY_CNT}, {27'd0, 3'd1, 2'd1});
    checkOutput("lol_flags_low", {30'd0, LINK_UP, BIT_ALGN_HOLD}, 32'd0);
    step_cycles(2);
    PLL_LOCK = 1'b1;
    step_cycles(2);
    checkOutput("lol_waiting_lock", 32'(STATE), 32'd1);
    step_cycles(1);
    checkOutput("lol_relock_train", {28'd0, STATE, RX_CLK_TRAIN_RESTART}, {28'd0, 3'd2, 1'b1});

    // Abort by LINK_EN in BIT_ALGN after one retry.
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    reset_dut();
    wait_state(3'd3, 20, "abort_reach_algn");
    BIT_ALGN_ERR = 1'b1;
    step_cycles(1);
    BIT_ALGN_ERR = 1'b0;
    checkOutput("abort_err_retry", {27'd0, STATE, RETRY_CNT}, {27'd0, 3'd1, 2'd1});
    wait_state(3'd3, 10, "abort_back_in_algn");
    LINK_EN = 1'b0;
    step_cycles(1);
    checkOutput("abort_en_low", {27'd0, STATE, RETRY_CNT}, 32'd0);

    // Reset during PRBS_CHECK.
    applyStimulus(1, 1, 1, 0, 1, 0, 0, 0);
    reset_dut();
    wait_state(3'd5, 40, "rst_reach_prbs");
    PRBS_ERR = 1'b1;
    step_cycles(1);
    PRBS_ERR = 1'b0;
    checkOutput("rst_cnt_before", 32'(PRBS_ERR_CNT), 32'd1);
    RESET = 1'b1;
    step_cycles(1);
    checkOutput("rst_outputs_cleared", out_vec(), 32'h0);
    RESET = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
